// File: rtl/nec_ir_pkg.sv
// ------------------------------------------------------------------
// nec_ir_pkg: shared FSM states, FIFO depth and NEC frame field map.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_PUSH   = 3'd2,
    ST_REJECT = 3'd3,
    ST_SKIP   = 3'd4
  } nec_state_e;

  localparam int FIFO_DEPTH  = 4;
  localparam int CMD_WIDTH   = 8;

  localparam int ADDR_LSB    = 24;
  localparam int ADDR_N_LSB  = 16;
  localparam int CMD_LSB     = 8;
  localparam int CMD_N_LSB   = 0;

  function automatic logic frame_valid(input logic [31:0] frame, input logic [7:0] addr);
    return (frame[ADDR_N_LSB +: 8] == ~frame[ADDR_LSB +: 8]) &&
           (frame[CMD_N_LSB  +: 8] == ~frame[CMD_LSB  +: 8]) &&
           (frame[ADDR_LSB   +: 8] == addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/command_fifo.sv
// ------------------------------------------------------------------
// command_fifo: first-word fall-through command queue, pop-frees-slot on full.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module command_fifo
  import nec_ir_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign valid_o   = (count_q != '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (w_do_push && !w_do_pop)      count_q <= count_q + CNT_W'(1);
      else if (w_do_pop && !w_do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nec_ir_command_controller.sv
// ------------------------------------------------------------------
// nec_ir_command_controller: validates NEC frames, suppresses repeats, queues commands.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module nec_ir_command_controller
  import nec_ir_pkg::*;
#(
  parameter int         CLOCK_SPEED = 50_000,
  parameter logic [7:0] ADDRESS     = 8'h00,
  parameter int         HOLDOFF_MS  = 150
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        rxReadyIN,
  input  logic [31:0] rxDataIN,
  output logic        cmdValidOUT,
  output logic [7:0]  cmdOUT,
  input  logic        cmdReadyIN,
  output logic        overflowOUT,
  output logic [7:0]  errorCountOUT
);

  localparam int HOLD_CYCLES = CLOCK_SPEED * HOLDOFF_MS;
  localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  nec_state_e       state_q;
  logic [31:0]      frame_q;
  logic             push_q;
  logic [7:0]       last_cmd_q;
  logic [7:0]       err_cnt_q;
  logic             overflow_q;
  logic             rx_ready_q;
  logic [HOLD_W-1:0] holdoff_q;
  logic [HOLD_W-1:0] holdoff_d;

  logic             w_edge;
  logic             w_pop;
  logic             w_full;
  logic [7:0]       w_cmd;

  assign w_edge        = rxReadyIN && !rx_ready_q;
  assign w_cmd         = frame_q[CMD_LSB +: 8];
  assign w_pop         = cmdValidOUT && cmdReadyIN;
  assign overflowOUT   = overflow_q;
  assign errorCountOUT = err_cnt_q;

  always_comb begin
    holdoff_d = holdoff_q;
    if (state_q == ST_PUSH || state_q == ST_SKIP) begin
      holdoff_d = HOLD_W'(HOLD_CYCLES - 1);
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rx_ready_q <= 1'b0;
      holdoff_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_ready_q <= rxReadyIN;
      holdoff_q  <= holdoff_d;
      if (push_q && w_full && !w_pop) overflow_q <= 1'b1;
    end
  end

  // Edge events outside IDLE fall through unhandled and are lost by design.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      push_q     <= 1'b0;
      last_cmd_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_edge) begin
            frame_q <= rxDataIN;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!frame_valid(frame_q, ADDRESS)) begin
            state_q <= ST_REJECT;
          end else if (w_cmd == last_cmd_q && holdoff_q != '0) begin
            state_q <= ST_SKIP;
          end else begin
            state_q <= ST_PUSH;
            push_q  <= 1'b1;
          end
        end
        ST_PUSH: begin
          last_cmd_q <= w_cmd;
          state_q    <= ST_IDLE;
        end
        ST_REJECT: begin
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  command_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clkIN),
    .rst_ni  (nResetIN),
    .push_i  (push_q),
    .data_i  (w_cmd),
    .pop_i   (w_pop),
    .data_o  (cmdOUT),
    .valid_o (cmdValidOUT),
    .full_o  (w_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_nec_ir_command_controller.sv
// ------------------------------------------------------------------
// tb_nec_ir_command_controller: scoreboard bench for the NEC command controller.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_nec_ir_command_controller;

  // 2 kHz x 10 ms keeps the suppression window at 20 cycles.
  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        nResetIN;
  logic        rxReadyIN;
  logic [31:0] rxDataIN;
  logic        cmdValidOUT;
  logic [7:0]  cmdOUT;
  logic        cmdReadyIN;
  logic        overflowOUT;
  logic [7:0]  errorCountOUT;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pops = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  nec_ir_command_controller #(
    .CLOCK_SPEED (2),
    .ADDRESS     (8'h00),
    .HOLDOFF_MS  (10)
  ) dut (
    .clkIN         (clk),
    .nResetIN      (nResetIN),
    .rxReadyIN     (rxReadyIN),
    .rxDataIN      (rxDataIN),
    .cmdValidOUT   (cmdValidOUT),
    .cmdOUT        (cmdOUT),
    .cmdReadyIN    (cmdReadyIN),
    .overflowOUT   (overflowOUT),
    .errorCountOUT (errorCountOUT)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] addr, input logic [7:0] cmd);
    return {addr, ~addr, cmd, ~cmd};
  endfunction

  // Every accepted pop is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (nResetIN && cmdValidOUT && cmdReadyIN) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        check_vec("sb_underflow", exp_q.size(), 1);
      end else begin
        check_vec("sb_cmd", cmdOUT, exp_q.pop_front());
      end
    end
  end

  task automatic send_frame(input logic [31:0] f, input bit expect_push, input bit pop_in_push);
    @(posedge clk); #1;
    rxDataIN  = f;
    rxReadyIN = 1'b1;
    if (expect_push) exp_q.push_back(f[15:8]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (pop_in_push) cmdReadyIN = 1'b1;
    @(posedge clk); #1;
    cmdReadyIN = 1'b0;
    @(posedge clk); #1;
    rxReadyIN = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag, input int exp_pops);
    n_pops = 0;
    cmdReadyIN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!cmdValidOUT) break;
    end
    cmdReadyIN = 1'b0;
    check_vec({tag, "_empty"}, cmdValidOUT, 0);
    check_vec({tag, "_pops"}, n_pops, exp_pops);
    check_vec({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nResetIN   = 1'b0;
    rxReadyIN  = 1'b0;
    rxDataIN   = '0;
    cmdReadyIN = 1'b0;
    idle(3);
    check_vec("rst_valid", cmdValidOUT, 0);
    check_vec("rst_cmd", cmdOUT, 8'h00);
    check_vec("rst_ovf", overflowOUT, 0);
    check_vec("rst_err", errorCountOUT, 0);
    nResetIN = 1'b1;
    idle(2);

    // Basic frame: valid appears in cycle N+3 after the edge.
    @(posedge clk); #1;
    rxDataIN  = 32'h00FF45BA;
    rxReadyIN = 1'b1;
    exp_q.push_back(8'h45);
    @(posedge clk); #1;
    check_vec("lat_n1", cmdValidOUT, 0);
    @(posedge clk); #1;
    check_vec("lat_n2", cmdValidOUT, 0);
    @(posedge clk); #1;
    check_vec("lat_n3_valid", cmdValidOUT, 1);
    check_vec("lat_n3_cmd", cmdOUT, 8'h45);
    idle(4);
    rxReadyIN = 1'b0;
    check_vec("level_once_valid", cmdValidOUT, 1);
    drain("basic", 1);
    check_vec("basic_cmd_zero", cmdOUT, 8'h00);

    // Bad inverted address, then wrong device address.
    send_frame(32'h00FE45BA, 1'b0, 1'b0);
    send_frame(32'h01FE45BA, 1'b0, 1'b0);
    check_vec("rej_err", errorCountOUT, 2);
    check_vec("rej_valid", cmdValidOUT, 0);

    // Repeat suppression inside the window, acceptance after it.
    idle(HOLD + 10);
    send_frame(mk(8'h00, 8'h45), 1'b1, 1'b0);
    send_frame(mk(8'h00, 8'h45), 1'b0, 1'b0);
    idle(HOLD + 10);
    send_frame(mk(8'h00, 8'h45), 1'b1, 1'b0);
    drain("holdoff", 2);

    // Five distinct commands into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(mk(8'h00, 8'(i)), (i <= 4), 1'b0);
    end
    check_vec("ovf_set", overflowOUT, 1);
    check_vec("ovf_err_kept", errorCountOUT, 2);
    drain("ovf", 4);
    check_vec("ovf_sticky", overflowOUT, 1);

    // Full FIFO with a pop in the push cycle.
    nResetIN = 1'b0;
    idle(1);
    check_vec("rst2_ovf", overflowOUT, 0);
    check_vec("rst2_err", errorCountOUT, 0);
    nResetIN = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      send_frame(mk(8'h00, 8'h11 + 8'(i)), 1'b1, 1'b0);
    end
    send_frame(mk(8'h00, 8'h15), 1'b1, 1'b1);
    check_vec("full_pp_ovf", overflowOUT, 0);
    check_vec("full_pp_head", cmdOUT, 8'h12);
    drain("full_pp", 4);

    // Reset asserted while the FSM sits in CHECK.
    idle(HOLD + 10);
    @(posedge clk); #1;
    rxDataIN  = mk(8'h00, 8'h77);
    rxReadyIN = 1'b1;
    @(posedge clk); #1;
    nResetIN = 1'b0;
    #1;
    check_vec("midrst_valid", cmdValidOUT, 0);
    check_vec("midrst_cmd", cmdOUT, 8'h00);
    check_vec("midrst_ovf", overflowOUT, 0);
    check_vec("midrst_err", errorCountOUT, 0);
    rxReadyIN = 1'b0;
    idle(1);
    nResetIN = 1'b1;
    idle(8);
    check_vec("midrst_nocmd", cmdValidOUT, 0);

    // Ready already high at reset release gives one event.
    nResetIN  = 1'b0;
    rxDataIN  = mk(8'h00, 8'h5A);
    rxReadyIN = 1'b1;
    exp_q.push_back(8'h5A);
    idle(1);
    nResetIN = 1'b1;
    idle(8);
    rxReadyIN = 1'b0;
    check_vec("rel_high_valid", cmdValidOUT, 1);
    drain("rel_high", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nec_ir_command_controller.md
NEC_IR_COMMAND_CONTROLLER -- requirements
Module: nec_ir_command_controller

Interface
REQ-001 SHALL have parameter CLOCK_SPEED, default 50_000; clkIN frequency in kHz.
REQ-002 SHALL have parameter ADDRESS, default 8'h00; accepted NEC device address.
REQ-003 SHALL have parameter HOLDOFF_MS, default 150; duplicate-command suppression window in ms.
REQ-004 SHALL have port clkIN input 1; the single clock; all logic on its rising edge.
REQ-005 SHALL have port nResetIN input 1; asynchronous, active-low reset.
REQ-006 SHALL have port rxReadyIN input 1; receiver frame-complete level, held high until the next frame starts.
REQ-007 SHALL have port rxDataIN input 32; received frame: [31:24] address, [23:16] inverted address, [15:8] command, [7:0] inverted command.
REQ-008 SHALL have port cmdValidOUT output 1; FIFO head holds a command.
REQ-009 SHALL have port cmdOUT output 8; command at FIFO head.
REQ-010 SHALL have port cmdReadyIN input 1; consumer accepts head when high with cmdValidOUT.
REQ-011 SHALL have port overflowOUT output 1; sticky, set when a valid command is dropped for FIFO full.
REQ-012 SHALL have port errorCountOUT output 8; saturating count of rejected frames.

Function
REQ-013 SHALL detect the rxReadyIN rising edge with one registered sample; a level held high SHALL produce exactly one event.
REQ-014 SHALL run FSM IDLE -> CHECK -> (PUSH | REJECT | SKIP) -> IDLE; each state one cycle.
REQ-015 IDLE: on edge event SHALL latch rxDataIN and go to CHECK (edge seen cycle N, CHECK cycle N+1).
REQ-016 CHECK: frame valid iff [23:16] == ~[31:24], [7:0] == ~[15:8], and [31:24] == ADDRESS.
REQ-017 CHECK: invalid -> REJECT; valid and command equals last accepted command with holdoff counter nonzero -> SKIP; otherwise -> PUSH.
REQ-018 REJECT SHALL increment errorCountOUT, saturating at 8'hFF.
REQ-019 SKIP SHALL drop the frame and reload the holdoff counter (held key keeps suppressing).
REQ-020 PUSH SHALL write the command to the FIFO if not full (else set overflowOUT), store it as last command, and reload the holdoff counter; cmdValidOUT high from cycle N+3 when FIFO was empty.
REQ-021 Holdoff counter SHALL load CLOCK_SPEED*HOLDOFF_MS-1 and decrement to zero once per cycle; zero means window expired.
REQ-022 Edge events arriving outside IDLE SHALL be ignored.
REQ-023 FIFO SHALL be 4 entries, first-word fall-through; pop on cmdValidOUT && cmdReadyIN.
REQ-024 Simultaneous push and pop SHALL succeed when full (pop frees the slot in the same cycle) and keep count unchanged.
REQ-025 Read/write pointers SHALL be 2 bits wrapping modulo 4; occupancy 3 bits, full = 4, empty = 0.
REQ-026 cmdOUT SHALL be 8'h00 when FIFO is empty.

Reset
REQ-027 nResetIN low SHALL asynchronously clear FSM to IDLE, FIFO empty, cmdValidOUT 0, cmdOUT 8'h00, overflowOUT 0, errorCountOUT 0, holdoff counter 0, last command 0, edge register 0.
REQ-028 Reset mid-frame or mid-FSM SHALL discard the in-flight frame; an rxReadyIN already high at reset release SHALL produce one event.
REQ-029 No state other than nResetIN SHALL clear overflowOUT or errorCountOUT.

Structure
REQ-030 FSM state enum, FIFO depth 4 and frame field bit positions SHALL live in a shared package nec_ir_pkg.
REQ-031 The FIFO SHALL be a sub-module command_fifo (width 8, depth 4).
REQ-032 Holdoff counter width SHALL be derived from CLOCK_SPEED*HOLDOFF_MS via $clog2.

Verification
REQ-033 Frame 32'h00FF45BA, ADDRESS 8'h00 -> cmdOUT 8'h45, cmdValidOUT high 3 cycles after edge; pop clears it.
REQ-034 Frames 32'h00FE45BA and 32'h01FE45BA -> nothing pushed, errorCountOUT 2.
REQ-035 Frame 8'h45 twice within 150 ms, then 8'h45 after 150 ms idle -> exactly two FIFO entries.
REQ-036 Five distinct valid frames, cmdReadyIN low -> 4 entries, overflowOUT 1; then drain order 1..4.
REQ-037 FIFO full, cmdReadyIN high in PUSH cycle -> push and pop both succeed, occupancy stays 4, overflowOUT stays 0.
REQ-038 Assert nResetIN during CHECK -> all outputs at reset values next cycle; no command emitted.
